// File: rtl/sata_xcvr_rst_sequencer_if.sv
// Signal bundle between the SATA link-level reset sequencer and its surroundings
// (link layer, transceiver reset controller, CDR lock status).
interface sata_xcvr_rst_sequencer_if;
    // Handshake: every signal is a level sampled on the rising clock edge. There is no
    // valid/ready pairing. req_reset is a request that holds while high. rc_tx_ready and
    // rc_rx_ready act as "ready" acknowledgements to rc_reset dropping. link_ready is the
    // channel-up status returned to the link layer.
    logic       req_reset;
    logic       rc_reset;
    logic       rc_tx_ready;
    logic       rc_rx_ready;
    logic       rx_is_lockedtodata;
    logic       link_ready;
    logic       fail;
    logic [2:0] retry_cnt;
    logic [2:0] dbg_state;

    modport master (
        input  req_reset,
        input  rc_tx_ready,
        input  rc_rx_ready,
        input  rx_is_lockedtodata,
        output rc_reset,
        output link_ready,
        output fail,
        output retry_cnt,
        output dbg_state
    );

    modport slave (
        output req_reset,
        output rc_tx_ready,
        output rc_rx_ready,
        output rx_is_lockedtodata,
        input  rc_reset,
        input  link_ready,
        input  fail,
        input  retry_cnt,
        input  dbg_state
    );
endinterface

// File: rtl/sata_xcvr_rst_sequencer.sv
// Reset sequencer for an Arria 10 SATA transceiver channel: hold, wait for tx/rx ready, retry, fail.
// Optional CDR lock-loss restart from READY is enabled with `define SATA_XCVR_RST_SEQ_LOL_MONITOR_EN.
module sata_xcvr_rst_sequencer #(
    parameter int unsigned RST_CYCLES = 16,
    parameter int unsigned TX_TIMEOUT = 65536,
    parameter int unsigned RX_TIMEOUT = 262144,
    parameter int unsigned LOL_FILTER = 8,
    parameter int unsigned RETRY_MAX  = 7
) (
    input  logic                        clock,
    input  logic                        reset,
    sata_xcvr_rst_sequencer_if.master   bus
);
    localparam int unsigned CNT_MAX_A = (RST_CYCLES > TX_TIMEOUT) ? RST_CYCLES : TX_TIMEOUT;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > RX_TIMEOUT) ? CNT_MAX_A : RX_TIMEOUT;
    localparam int unsigned CW        = $clog2(CNT_MAX);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TX_LAST   = CW'(TX_TIMEOUT - 1);
    localparam logic [CW-1:0] RX_LAST   = CW'(RX_TIMEOUT - 1);
    localparam logic [2:0]    RETRY_LIM = 3'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_HOLD    = 3'd0,
        S_WAIT_TX = 3'd1,
        S_WAIT_RX = 3'd2,
        S_READY   = 3'd3,
        S_FAIL    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          cnt_clr;
    logic [2:0]    retry_q, retry_d;
    logic          timeout;
    logic          lol_hit;

`ifdef SATA_XCVR_RST_SEQ_LOL_MONITOR_EN
    localparam int unsigned LW = $clog2(LOL_FILTER + 1);
    localparam logic [LW-1:0] LOL_LAST = LW'(LOL_FILTER - 1);
    localparam logic [LW-1:0] LOL_SAT  = LW'(LOL_FILTER);

    logic [LW-1:0] lol_cnt_q;

    // The LOL_FILTER-th consecutive low sample trips on the edge it is seen.
    assign lol_hit = (state_q == S_READY) && !bus.rx_is_lockedtodata && (lol_cnt_q == LOL_LAST);

    always_ff @(posedge clock) begin
        if (reset || state_d != S_READY) begin
            lol_cnt_q <= '0;
        end else if (state_q != S_READY || bus.rx_is_lockedtodata) begin
            lol_cnt_q <= '0;
        end else if (lol_cnt_q != LOL_SAT) begin
            lol_cnt_q <= lol_cnt_q + 1'b1;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = bus.rx_is_lockedtodata;
    assign lol_hit     = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (state_q == S_HOLD || state_q == S_WAIT_TX || state_q == S_WAIT_RX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        cnt_clr = 1'b0;
        timeout = 1'b0;
        if (bus.req_reset) begin
            state_d = S_HOLD;
            retry_d = '0;
            cnt_clr = 1'b1;
        end else if (lol_hit) begin
            state_d = S_HOLD;
            retry_d = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == RST_LAST) state_d = S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (bus.rc_tx_ready)        state_d = S_WAIT_RX;
                    else if (cnt_q == TX_LAST)  timeout = 1'b1;
                end
                S_WAIT_RX: begin
                    // Ready beats a coincident timeout; a tx drop aborts at once.
                    if (bus.rc_rx_ready && bus.rc_tx_ready) state_d = S_READY;
                    else if (!bus.rc_tx_ready)              timeout = 1'b1;
                    else if (cnt_q == RX_LAST)              timeout = 1'b1;
                end
                S_READY: begin
                    if (!bus.rc_tx_ready || !bus.rc_rx_ready) begin
                        state_d = S_HOLD;
                        retry_d = '0;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_HOLD;
                    retry_d = '0;
                end
            endcase
            if (timeout) begin
                if (retry_q == RETRY_LIM) begin
                    state_d = S_FAIL;
                end else begin
                    state_d = S_HOLD;
                    retry_d = retry_q + 3'd1;
                end
            end
        end
        if (state_d != state_q) cnt_clr = 1'b1;
    end

    always_comb begin
        bus.rc_reset   = (state_q == S_HOLD) || (state_q == S_FAIL);
        bus.link_ready = (state_q == S_READY);
        bus.fail       = (state_q == S_FAIL);
        bus.retry_cnt  = retry_q;
        bus.dbg_state  = state_q;
    end
endmodule

// File: tb/tb_sata_xcvr_rst_sequencer.sv
// Bench for sata_xcvr_rst_sequencer: directed bring-up/timeout/lock scenarios then random
// stimulus, every cycle compared against a countdown-based behavioural model.
module tb_sata_xcvr_rst_sequencer;
    localparam int RST  = 4;
    localparam int TXT  = 32;
    localparam int RXT  = 64;
    localparam int LOLF = 8;
    localparam int RMAX = 2;

    localparam int P_HOLD = 0, P_WAIT_TX = 1, P_WAIT_RX = 2, P_READY = 3, P_FAIL = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sata_xcvr_rst_sequencer_if bus ();

    sata_xcvr_rst_sequencer #(
        .RST_CYCLES (RST),
        .TX_TIMEOUT (TXT),
        .RX_TIMEOUT (RXT),
        .LOL_FILTER (LOLF),
        .RETRY_MAX  (RMAX)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;
    logic [5:0] exp_q[$];

    int m_phase, m_left, m_tries, m_lol;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic give_up();
        if (m_tries == RMAX) begin
            m_phase = P_FAIL;
        end else begin
            m_tries++;
            m_phase = P_HOLD;
            m_left  = RST;
        end
    endtask

    task automatic model_step();
        logic tx, rx, lk, lost;
        tx = bus.rc_tx_ready;
        rx = bus.rc_rx_ready;
        lk = bus.rx_is_lockedtodata;
        if (reset || bus.req_reset) begin
            m_phase = P_HOLD;
            m_left  = RST;
            m_tries = 0;
            m_lol   = 0;
        end else begin
            case (m_phase)
                P_HOLD: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = P_WAIT_TX;
                        m_left  = TXT;
                    end
                end
                P_WAIT_TX: begin
                    if (tx) begin
                        m_phase = P_WAIT_RX;
                        m_left  = RXT;
                    end else begin
                        m_left--;
                        if (m_left == 0) give_up();
                    end
                end
                P_WAIT_RX: begin
                    if (tx && rx) begin
                        m_phase = P_READY;
                        m_lol   = 0;
                    end else if (!tx) begin
                        give_up();
                    end else begin
                        m_left--;
                        if (m_left == 0) give_up();
                    end
                end
                P_READY: begin
                    lost = 1'b0;
`ifdef SATA_XCVR_RST_SEQ_LOL_MONITOR_EN
                    m_lol = lk ? 0 : m_lol + 1;
                    lost  = (m_lol >= LOLF);
`endif
                    if (lost || !tx || !rx) begin
                        m_phase = P_HOLD;
                        m_left  = RST;
                        m_tries = 0;
                    end
                end
                default: ;
            endcase
        end
        exp_q.push_back({(m_phase == P_HOLD || m_phase == P_FAIL), (m_phase == P_READY),
                         (m_phase == P_FAIL), 3'(m_tries)});
    endtask

    task automatic tick();
        logic [5:0] e;
        @(posedge clock);
        model_step();
        #1;
        e = exp_q.pop_front();
        check_eq("rc_reset", 32'(bus.rc_reset), 32'(e[5]));
        check_eq("link_ready", 32'(bus.link_ready), 32'(e[4]));
        check_eq("fail", 32'(bus.fail), 32'(e[3]));
        check_eq("retry_cnt", 32'(bus.retry_cnt), 32'(e[2:0]));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_link(input string tag);
        int n;
        n = 0;
        while (!bus.link_ready && n < 200) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(bus.link_ready), 32'd1);
    endtask

    initial begin
        int hi, n;
        reset = 1'b1;
        bus.req_reset = 1'b0;
        bus.rc_tx_ready = 1'b0;
        bus.rc_rx_ready = 1'b0;
        bus.rx_is_lockedtodata = 1'b1;
        #2;
        ticks(3);
        check_eq("reset_rc_reset", 32'(bus.rc_reset), 32'd1);
        check_eq("reset_link_ready", 32'(bus.link_ready), 32'd0);

        // Nominal bring-up
        reset = 1'b0;
        hi = 0;
        for (int c = 0; c < 30; c++) begin
            bus.rc_tx_ready = (c >= 10);
            bus.rc_rx_ready = (c >= 20);
            if (bus.rc_reset) hi++;
            tick();
            if (c == 19) check_eq("link_before_rx", 32'(bus.link_ready), 32'd0);
            if (c == 20) check_eq("link_at_rx", 32'(bus.link_ready), 32'd1);
        end
        check_eq("rst_hold_len", 32'(hi), 32'(RST));
        check_eq("nominal_retry", 32'(bus.retry_cnt), 32'd0);

        // TX never ready: three attempts then FAIL
        bus.rc_tx_ready = 1'b0;
        bus.rc_rx_ready = 1'b0;
        bus.req_reset = 1'b1;
        tick();
        bus.req_reset = 1'b0;
        n = 0;
        while (!bus.fail && n < 300) begin
            tick();
            n++;
        end
        check_eq("fail_reached", 32'(bus.fail), 32'd1);
        check_eq("fail_cycles", 32'(n), 32'(3 * (RST + TXT)));
        check_eq("fail_retry", 32'(bus.retry_cnt), 32'(RMAX));
        ticks(10);
        check_eq("fail_rc_reset", 32'(bus.rc_reset), 32'd1);
        bus.req_reset = 1'b1;
        tick();
        bus.req_reset = 1'b0;
        check_eq("fail_cleared", 32'(bus.fail), 32'd0);
        check_eq("fail_retry_cleared", 32'(bus.retry_cnt), 32'd0);

        // req_reset mid WAIT_RX at cnt 30
        bus.rc_tx_ready = 1'b1;
        n = 0;
        while (bus.rc_reset && n < 20) begin
            tick();
            n++;
        end
        tick();
        ticks(30);
        bus.req_reset = 1'b1;
        tick();
        bus.req_reset = 1'b0;
        check_eq("req_to_hold", 32'(bus.rc_reset), 32'd1);
        ticks(40);
        check_eq("req_no_timeout", 32'(bus.retry_cnt), 32'd0);

        // READY, then a 1-cycle rx drop
        bus.rc_rx_ready = 1'b1;
        wait_link("link_up_a");
        bus.rc_rx_ready = 1'b0;
        tick();
        check_eq("rx_drop_link", 32'(bus.link_ready), 32'd0);
        check_eq("rx_drop_hold", 32'(bus.rc_reset), 32'd1);
        bus.rc_rx_ready = 1'b1;
        wait_link("link_up_b");

        // Lock loss filter
        bus.rx_is_lockedtodata = 1'b0;
        ticks(7);
        bus.rx_is_lockedtodata = 1'b1;
        tick();
        check_eq("lol_7_kept", 32'(bus.link_ready), 32'd1);
        bus.rx_is_lockedtodata = 1'b0;
        ticks(8);
`ifdef SATA_XCVR_RST_SEQ_LOL_MONITOR_EN
        check_eq("lol_8_drop", 32'(bus.link_ready), 32'd0);
        bus.rx_is_lockedtodata = 1'b1;
        wait_link("link_up_c");
`else
        ticks(92);
        check_eq("lol_ignored", 32'(bus.link_ready), 32'd1);
        bus.rx_is_lockedtodata = 1'b1;
`endif

        // Random stimulus
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) bus.rc_tx_ready = ~bus.rc_tx_ready;
            if ($urandom_range(0, 29) == 0) bus.rc_rx_ready = ~bus.rc_rx_ready;
            if ($urandom_range(0, 19) == 0) bus.rx_is_lockedtodata = ~bus.rx_is_lockedtodata;
            bus.req_reset = ($urandom_range(0, 299) == 0);
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0;
        bus.req_reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
